isp_vga_pixel_feeder: RTL and testbench
=======================================

// Module: isp_vga_pixel_feeder
// PURPOSE
//  Elastic pixel stage directly upstream of the VGA timing driver. Accepts the sensor-side RGB565
//  stream (valid/ready, SOF/EOL markers) into a FIFO and delivers one RGB888 pixel per display
//  request, aligned to display frame start. Flags underflow and line-length errors; self-resyncs.
// PARAMETERS
//  H_PIXELS    640   active pixels per line (EOL expected on pixel H_PIXELS-1)
//  V_LINES     480   active lines per frame
//  DEPTH       1024  FIFO depth in RGB565 words, power of two
//  ADDR_W      10    log2(DEPTH)
//  PREFILL     320   FIFO level required before streaming may start
// PORTS
//  clock        in   1   pixel clock, 25 MHz; all logic on rising edge
//  reset        in   1   synchronous, active-high
//  in_valid     in   1   sensor pixel valid
//  in_ready     out  1   FIFO can accept; transfer = in_valid & in_ready
//  in_data      in   16  RGB565 {r[15:11],g[10:5],b[4:0]}
//  in_sof       in   1   qualifies first pixel of frame
//  in_eol       in   1   qualifies last pixel of line
//  frame_start  in   1   1-cycle pulse from VGA driver, cycle before first active pixel
//  pix_req      in   1   VGA driver consumes one pixel this cycle (active region)
//  red/green/blue out 8 each   RGB888 pixel, valid cycle after pix_req
//  pix_valid    out  1   red/green/blue carry real data this cycle
//  underflow    out  1   sticky: pix_req seen while streaming with FIFO empty
//  line_err     out  1   sticky: EOL position != H_PIXELS-1, or missing EOL
//  level        out  ADDR_W+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: state WAIT_SOF, FIFO empty, all outputs 0 (in_ready 0 in reset cycle, 1 thereafter).
//  States: WAIT_SOF -> FILL -> STREAM -> RESYNC -> WAIT_SOF.
//   WAIT_SOF: in_ready=1; input beats dropped until a beat with in_sof; that beat written; ->FILL.
//   FILL: write accepted beats; no reads; ->STREAM on frame_start when level>=PREFILL
//     (frame_start with level<PREFILL ignored; wait for next frame_start).
//   STREAM: pix_req & !empty -> read; pix_req & empty -> underflow<=1, output black, ->RESYNC.
//     frame_start while out-pixel counter !=0 -> ->RESYNC (misalignment).
//   RESYNC: 1 cycle; FIFO pointers cleared, counters cleared, in_ready=0; ->WAIT_SOF.
//  FIFO: in_ready = (level<DEPTH) & state!=RESYNC. Simultaneous read+write: level unchanged.
//   Full: write blocked; read in same cycle frees slot next cycle (no same-cycle pass-through).
//   Empty + write + pix_req same cycle: underflow (no bypass). Pointers wrap mod DEPTH.
//  Output latency 1 cycle: pix_req at N -> pix_valid/RGB at N+1; otherwise pix_valid=0, RGB=0.
//  Expansion: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
//  Out counter: counts reads, wraps at H_PIXELS*V_LINES to 0.
//  In column counter: increments per accepted beat, clears on EOL or SOF; line_err<=1 if EOL at
//   col!=H_PIXELS-1 or col reaches H_PIXELS without EOL (counter then clears).
//  Sticky flags clear only on reset; in_sof mid-line in FILL/STREAM restarts column count only.
// CONFIGURATION
//  TEST_PATTERN_EN defined: extra input pattern_sel (1b). When 1, RGB driven from 8 vertical
//   colour bars (width H_PIXELS/8, white,yellow,cyan,green,magenta,red,blue,black) indexed by
//   out-pixel column; FIFO still read/flagged identically. Undefined: no port, FIFO data only.
// TESTING
//  reset, then 640-pixel lines with SOF on pixel 0 -> in_ready=1, level rises, state FILL.
//  level=320, frame_start, pix_req x640 -> pix_valid 640 cycles, in_data 16'hF800 -> RGB FF,00,00.
//  stop input, keep pix_req until empty -> underflow=1, black out, RESYNC then WAIT_SOF, level=0.
//  fill to 1024, in_valid held, no pix_req -> in_ready=0; one pix_req -> in_ready=1 next cycle.
//  EOL on pixel 639 -> line_err=0; EOL on pixel 600 -> line_err=1, stays 1 until reset.
//  TEST_PATTERN_EN, pattern_sel=1, data 16'h0000 -> column 0 RGB FFFFFF, column 560 RGB 000000.

Source files
------------

// File: rtl/isp_vga_pixel_feeder_if.sv
// rtl/isp_vga_pixel_feeder_if.sv - sensor stream and display pixel signals of the VGA pixel feeder
interface isp_vga_pixel_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sof;
  logic        in_eol;
  logic        frame_start;
  logic        pix_req;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        pix_valid;

  modport master (
    output in_valid, in_data, in_sof, in_eol, frame_start, pix_req,
    input  in_ready, red, green, blue, pix_valid
  );

  modport slave (
    input  in_valid, in_data, in_sof, in_eol, frame_start, pix_req,
    output in_ready, red, green, blue, pix_valid
  );
endinterface

// File: rtl/isp_vga_pixel_feeder.sv
// rtl/isp_vga_pixel_feeder.sv - RGB565 FIFO to RGB888 display feeder with frame alignment and error flags
// TEST_PATTERN_EN adds pattern_sel, which replaces FIFO data with eight vertical colour bars.
module isp_vga_pixel_feeder #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int PREFILL  = 320
) (
  input  logic                    clock,
  input  logic                    reset,
  isp_vga_pixel_feeder_if.slave   px,
`ifdef TEST_PATTERN_EN
  input  logic                    pattern_sel,
`endif
  output logic                    underflow,
  output logic                    line_err,
  output logic [ADDR_W:0]         level
);

  localparam int OUT_W = $clog2(H_PIXELS * V_LINES);
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PREFILL_L = (ADDR_W+1)'(PREFILL);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(H_PIXELS * V_LINES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);

  typedef enum logic [1:0] {WAIT_SOF, FILL, STREAM, RESYNC} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]  in_col_q, in_col_d;
  logic              underflow_q, underflow_d, line_err_q, line_err_d;
  logic              pix_valid_q, pix_valid_d;
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic [15:0] mem [DEPTH];
  logic        in_ready, wr_en, rd_en, uf_evt, clr, empty;
  logic [15:0] rd_word;
  logic [COL_W-1:0] col_cur;

`ifdef TEST_PATTERN_EN
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [2:0]       bar;
  logic [23:0]      bar_rgb;
`endif

  assign empty   = (level_q == '0);
  assign rd_word = mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_cnt_q   <= '0;
      in_col_q    <= '0;
      underflow_q <= 1'b0;
      line_err_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_cnt_q   <= out_cnt_d;
      in_col_q    <= in_col_d;
      underflow_q <= underflow_d;
      line_err_q  <= line_err_d;
      pix_valid_q <= pix_valid_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= px.in_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: if (wr_en) state_d = FILL;
      FILL:     if (px.frame_start && level_q >= PREFILL_L) state_d = STREAM;
      // A display frame starting mid-image means we lost alignment; drop everything and resync.
      STREAM:   if ((px.frame_start && out_cnt_q != '0) || uf_evt) state_d = RESYNC;
      default:  state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    in_ready = !reset && (level_q != DEPTH_L) && (state_q != RESYNC);
    wr_en    = px.in_valid && in_ready && (state_q != WAIT_SOF || px.in_sof);
    rd_en    = (state_q == STREAM) && px.pix_req && !empty;
    uf_evt   = (state_q == STREAM) && px.pix_req && empty;
    clr      = (state_q == RESYNC);
  end

`ifdef TEST_PATTERN_EN
  always_comb begin
    bar = 3'(out_col_q / COL_W'(H_PIXELS / 8));
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    out_col_d = out_col_q;
    if (clr) out_col_d = '0;
    else if (rd_en) out_col_d = (out_col_q == COL_LAST) ? '0 : out_col_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) out_col_q <= '0;
    else       out_col_q <= out_col_d;
  end
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_cnt_d   = out_cnt_q;
    in_col_d    = in_col_q;
    underflow_d = underflow_q || uf_evt;
    line_err_d  = line_err_q;
    pix_valid_d = rd_en;
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    col_cur     = px.in_sof ? '0 : in_col_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      out_cnt_d = (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
`ifdef TEST_PATTERN_EN
      if (pattern_sel) begin
        {red_d, green_d, blue_d} = bar_rgb;
      end else
`endif
      begin
        red_d   = {rd_word[15:11], rd_word[15:13]};
        green_d = {rd_word[10:5],  rd_word[10:9]};
        blue_d  = {rd_word[4:0],   rd_word[4:2]};
      end
    end
    if (wr_en && !rd_en)      level_d = level_q + 1'b1;
    else if (rd_en && !wr_en) level_d = level_q - 1'b1;

    // Position of the current beat is 0 on SOF; an EOL elsewhere, or no EOL by the last column, is an error.
    if (wr_en) begin
      if (px.in_eol) begin
        if (col_cur != COL_LAST) line_err_d = 1'b1;
        in_col_d = '0;
      end else if (col_cur == COL_LAST) begin
        line_err_d = 1'b1;
        in_col_d   = '0;
      end else begin
        in_col_d = col_cur + 1'b1;
      end
    end

    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      out_cnt_d = '0;
      in_col_d  = '0;
    end
  end

  assign px.in_ready  = in_ready;
  assign px.pix_valid = pix_valid_q;
  assign px.red       = red_q;
  assign px.green     = green_q;
  assign px.blue      = blue_q;
  assign underflow    = underflow_q;
  assign line_err     = line_err_q;
  assign level        = level_q;

endmodule

// File: tb/tb_isp_vga_pixel_feeder.sv
// tb/tb_isp_vga_pixel_feeder.sv - directed self-checking bench for isp_vga_pixel_feeder
module tb_isp_vga_pixel_feeder;
  logic        clock = 1'b0;
  logic        reset;
  logic        underflow, line_err;
  logic [10:0] level;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif
  int passed = 0;
  int total  = 0;

  always #20 clock = ~clock;

  isp_vga_pixel_feeder_if px ();

  isp_vga_pixel_feeder dut (
    .clock       (clock),
    .reset       (reset),
    .px          (px.slave),
`ifdef TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .underflow   (underflow),
    .line_err    (line_err),
    .level       (level)
  );

  function automatic logic [15:0] vec(input int i);
    case (i)
      0:       return 16'hF800;
      1:       return 16'h07E0;
      2:       return 16'h001F;
      3:       return 16'h8410;
      default: return 16'hF800;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input int i);
    case (i)
      0:       return 24'hFF0000;
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      3:       return 24'h848284;
      default: return 24'hFF0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    px.in_valid = 0; px.in_data = '0; px.in_sof = 0; px.in_eol = 0;
    px.frame_start = 0; px.pix_req = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1; tick(); tick();
    reset = 0; #1;
  endtask

  task automatic send_beats(input int first, input int n, input int eol_at);
    for (int i = 0; i < n; i++) begin
      px.in_valid = 1;
      px.in_data  = vec(first + i);
      px.in_sof   = (first + i == 0);
      px.in_eol   = (first + i == eol_at);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); #1;
    total++; if (px.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", px.in_ready); else passed++;
    total++; if (level !== 11'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    total++; if ({px.pix_valid, underflow, line_err, px.red, px.green, px.blue} !== 27'd0)
      $display("FAIL reset_outputs got %h want 0", {px.pix_valid, underflow, line_err, px.red, px.green, px.blue}); else passed++;
    reset = 0; #1;
    total++; if (px.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", px.in_ready); else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 3; i++) begin
      px.in_valid = 1; px.in_data = 16'h1234; tick();
    end
    idle();
    total++; if (level !== 11'd0) $display("FAIL drop_before_sof level got %0d want 0", level); else passed++;
    send_beats(0, 100, 639);
    total++; if (level !== 11'd100) $display("FAIL fill_level got %0d want 100", level); else passed++;
    px.frame_start = 1; tick(); px.frame_start = 0;
    px.pix_req = 1; tick(); px.pix_req = 0;
    total++; if (px.pix_valid !== 1'b0 || level !== 11'd100)
      $display("FAIL early_frame_start pix_valid %b level %0d want 0 100", px.pix_valid, level); else passed++;
    send_beats(100, 540, 639);
    total++; if (level !== 11'd640) $display("FAIL line_level got %0d want 640", level); else passed++;
    total++; if (line_err !== 1'b0) $display("FAIL good_eol line_err got %b want 0", line_err); else passed++;
  endtask

  task automatic test_stream();
    int bad = 0;
    px.frame_start = 1; tick(); px.frame_start = 0;
    for (int i = 0; i < 640; i++) begin
      px.pix_req = 1; tick();
      if (i == 0 || i == 3) begin
        total++; if ({px.red, px.green, px.blue} !== exp_rgb(i))
          $display("FAIL stream_rgb_%0d got %h want %h", i, {px.red, px.green, px.blue}, exp_rgb(i)); else passed++;
      end
      if (px.pix_valid !== 1'b1 || {px.red, px.green, px.blue} !== exp_rgb(i)) bad++;
    end
    px.pix_req = 0;
    total++; if (bad != 0) $display("FAIL stream_pixels bad %0d want 0", bad); else passed++;
    tick();
    total++; if (px.pix_valid !== 1'b0 || {px.red, px.green, px.blue} !== 24'd0)
      $display("FAIL idle_output pix_valid %b rgb %h want 0 0", px.pix_valid, {px.red, px.green, px.blue}); else passed++;
    total++; if (level !== 11'd0 || underflow !== 1'b0)
      $display("FAIL drained level %0d underflow %b want 0 0", level, underflow); else passed++;
  endtask

  task automatic test_underflow();
    px.pix_req = 1; tick(); px.pix_req = 0;
    total++; if (underflow !== 1'b1) $display("FAIL underflow_set got %b want 1", underflow); else passed++;
    total++; if (px.pix_valid !== 1'b0 || {px.red, px.green, px.blue} !== 24'd0)
      $display("FAIL underflow_black pix_valid %b rgb %h want 0 0", px.pix_valid, {px.red, px.green, px.blue}); else passed++;
    total++; if (px.in_ready !== 1'b0) $display("FAIL resync_in_ready got %b want 0", px.in_ready); else passed++;
    tick();
    total++; if (px.in_ready !== 1'b1 || level !== 11'd0 || underflow !== 1'b1)
      $display("FAIL after_resync in_ready %b level %0d underflow %b want 1 0 1", px.in_ready, level, underflow); else passed++;
  endtask

  task automatic test_line_err();
    do_reset();
    send_beats(0, 601, 600);
    total++; if (line_err !== 1'b1) $display("FAIL short_eol line_err got %b want 1", line_err); else passed++;
    send_beats(1000, 100, -1);
    total++; if (line_err !== 1'b1) $display("FAIL line_err_sticky got %b want 1", line_err); else passed++;
    do_reset();
    total++; if (line_err !== 1'b0) $display("FAIL line_err_reset got %b want 0", line_err); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    px.in_valid = 1; px.in_data = 16'h07E0; px.in_sof = 1; tick();
    px.in_sof = 0;
    repeat (1030) tick();
    total++; if (level !== 11'd1024 || px.in_ready !== 1'b0)
      $display("FAIL full level %0d in_ready %b want 1024 0", level, px.in_ready); else passed++;
    total++; if (line_err !== 1'b1) $display("FAIL missing_eol line_err got %b want 1", line_err); else passed++;
    px.frame_start = 1; tick(); px.frame_start = 0;
    px.pix_req = 1; #1;
    total++; if (px.in_ready !== 1'b0) $display("FAIL full_no_passthrough in_ready %b want 0", px.in_ready); else passed++;
    tick();
    total++; if (px.in_ready !== 1'b1 || level !== 11'd1023)
      $display("FAIL read_frees_slot in_ready %b level %0d want 1 1023", px.in_ready, level); else passed++;
    total++; if (px.pix_valid !== 1'b1 || {px.red, px.green, px.blue} !== 24'h00FF00)
      $display("FAIL green_pixel pix_valid %b rgb %h want 1 00ff00", px.pix_valid, {px.red, px.green, px.blue}); else passed++;
    tick();
    total++; if (level !== 11'd1023) $display("FAIL read_write_level got %0d want 1023", level); else passed++;
    px.pix_req = 0; tick();
    total++; if (level !== 11'd1024 || px.in_ready !== 1'b0)
      $display("FAIL refill level %0d in_ready %b want 1024 0", level, px.in_ready); else passed++;
    px.frame_start = 1; tick(); px.frame_start = 0; px.in_valid = 0;
    total++; if (px.in_ready !== 1'b0) $display("FAIL misalign_resync in_ready %b want 0", px.in_ready); else passed++;
    tick();
    total++; if (level !== 11'd0 || underflow !== 1'b0)
      $display("FAIL misalign_cleared level %0d underflow %b want 0 0", level, underflow); else passed++;
    idle();
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    do_reset();
    pattern_sel = 1;
    for (int i = 0; i < 640; i++) begin
      px.in_valid = 1; px.in_data = 16'h0000; px.in_sof = (i == 0); px.in_eol = (i == 639); tick();
    end
    idle();
    px.frame_start = 1; tick(); px.frame_start = 0;
    for (int i = 0; i < 640; i++) begin
      px.pix_req = 1; tick();
      if (i == 0) begin
        total++; if ({px.red, px.green, px.blue} !== 24'hFFFFFF)
          $display("FAIL bar_col0 got %h want ffffff", {px.red, px.green, px.blue}); else passed++;
      end
      if (i == 80) begin
        total++; if ({px.red, px.green, px.blue} !== 24'hFFFF00)
          $display("FAIL bar_col80 got %h want ffff00", {px.red, px.green, px.blue}); else passed++;
      end
      if (i == 560) begin
        total++; if ({px.red, px.green, px.blue} !== 24'h000000 || px.pix_valid !== 1'b1)
          $display("FAIL bar_col560 got %h valid %b want 000000 1", {px.red, px.green, px.blue}, px.pix_valid); else passed++;
      end
    end
    px.pix_req = 0; pattern_sel = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_underflow();
    test_line_err();
    test_full();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
